mc_control: RTL and testbench
=============================

# mc_control

Multicycle control unit for the 32-bit MIPS core. It decodes `instr[31:26]`/`instr[5:0]` and steps a Moore state machine that drives every select and enable of the multicycle datapath. It sits directly upstream of the datapath and consumes its `zero`, `sign` and `overflow` flags. It also owns the data-memory write strobe, the memory wait handshake, and the arithmetic-overflow and illegal-instruction indications.

## Interface
- `STATEBITS`, 4: width of state register / debug port.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]`.
- `funct` in 6: `instr[5:0]`.
- `zero`, `sign`, `overflow` in 1 each: combinational ALU flags from datapath.
- `memready` in 1: data memory done (read data valid / write accepted).
- `memwrite` out 1: data memory write strobe.
- `memtoreg`, `iord`, `regwrite`, `regdst`, `irwrite`, `pcen` out 1 each: datapath controls.
- `pcsource`, `alusrca`, `alusrcb` out 2 each: datapath mux selects.
- `alucont` out 5: ALU operation.
- `ovf_trap` out 1: one-cycle pulse, signed overflow suppressed a writeback.
- `illegal` out 1: one-cycle pulse, undecodable instruction.
- `state` out `STATEBITS`: current state (debug).

## Operation
- Mux encodings:
  - `alusrca`: 00 pc, 01 A, 10 B, 11 const 1.
  - `alusrcb`: 00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
  - `pcsource`: 00 aluresult, 01 aluout, 10 jump target, 11 A.
  - `regdst`: 0 rt, 1 rd.
  - `memtoreg`: 0 aluout, 1 mdr.
- `alucont`: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 NOR, 00110 SLT.
- Supported ops:
  - R-type (op 000000): funct 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 001000 jr.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, addiu 001001, slti 001010, j 000010.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, JUMP 9, JR 10, IEX 11, IWB 12. Codes 13-15 go to FETCH.
- Per-state outputs and transitions (unlisted outputs are 0):
  - FETCH: srca 00, srcb 01, ADD, pcsource 00, `pcen`=1, `irwrite`=1 -> DECODE.
  - DECODE: srca 00, srcb 11, ADD (branch target into aluout). Next state:
    - lw/sw -> MEMADR; R-type -> REX; R-type jr -> JR; beq/bne -> BRANCH; j -> JUMP; addi/addiu/slti -> IEX.
    - anything else -> FETCH with `illegal`=1.
  - MEMADR: srca 01, srcb 10, ADD -> MEMRD (lw) / MEMWR (sw).
  - MEMRD: `iord`=1; holds while `memready`=0, else -> MEMWB.
  - MEMWB: regdst 0, memtoreg 1, `regwrite` -> FETCH.
  - MEMWR: `iord`=1, `memwrite`=1; holds while `memready`=0, else -> FETCH.
  - REX: srca 01, srcb 00, alucont from funct (add/addu ADD, sub/subu SUB, slt SLT, logic as named) -> RWB.
  - RWB: regdst 1, memtoreg 0, `regwrite`=~ovf_q -> FETCH.
  - IEX: srca 01, srcb 10, ADD (addi/addiu) or SLT (slti) -> IWB.
  - IWB: regdst 0, memtoreg 0, `regwrite`=~ovf_q -> FETCH.
  - BRANCH: srca 01, srcb 00, SUB, pcsource 01; `pcen`=zero (beq) / ~zero (bne) -> FETCH.
  - JUMP: pcsource 10, `pcen`=1 -> FETCH. JR: pcsource 11, `pcen`=1 -> FETCH.
- Overflow flop `ovf_q`:
  - Loaded at end of REX/IEX with `overflow` only for add, sub, addi; forced 0 for addu, subu, addiu, slti, logic ops.
  - Cleared in FETCH.
  - `ovf_trap` = `ovf_q` during RWB/IWB.
- `sign` is unused by current opcodes; the port is reserved for blez/bgtz.

## Timing
- Moore outputs are decoded from state. `pcen` in BRANCH is combinational from `zero`.
- Latency with zero waits, in cycles: R-type 4, addi/addiu/slti 4, lw 5, sw 4, beq/bne 3, j 3, jr 3, illegal 2.
- Each cycle `memready` is low in MEMRD/MEMWR adds one cycle. `memwrite` stays high for every cycle spent in MEMWR.
- `memready` is ignored outside MEMRD/MEMWR.
- Reset:
  - `reset` high at an edge forces state FETCH and `ovf_q` 0.
  - While `reset` is high, `pcen`, `regwrite`, `memwrite`, `irwrite`, `ovf_trap`, `illegal` are 0; other outputs show FETCH values.
  - Reset during any state, including a memory wait, abandons the instruction; the first FETCH after release is a full fetch.
- `op`/`funct` are sampled only in DECODE, REX, IEX, BRANCH and MEMADR, and must be stable from DECODE to instruction end.

## Test plan
- Reset held 3 cycles mid-MEMRD, then released -> state 0, `pcen`/`regwrite`/`memwrite` 0 during reset; first post-reset cycle FETCH with `pcen`=1, `irwrite`=1.
- add (op 0, funct 100000) with `overflow`=0 -> states 0,1,6,7; REX alucont 00000; RWB regwrite=1, regdst=1. Repeat with `overflow`=1 in REX -> RWB regwrite=0, `ovf_trap`=1 for one cycle. addu with `overflow`=1 -> regwrite=1, no trap.
- lw with `memready` low 2 cycles -> states 0,1,2,3,3,3,4; iord=1 in state 3; MEMWB memtoreg=1, regdst=0; 7 cycles total.
- sw with `memready`=1 -> states 0,1,2,5; memwrite=1 exactly one cycle; regwrite never 1.
- beq with zero=1 -> BRANCH pcen=1, pcsource=01. beq with zero=0 -> pcen=0. bne inverted. j -> pcsource=10, pcen=1. jr -> pcsource=11, pcen=1; all 3 cycles.
- op 111111 -> states 0,1,0; `illegal`=1 in DECODE only; no regwrite/memwrite.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore FSM that sequences the multicycle datapath,
// with the data-memory wait handshake, an overflow-trap flop and illegal-opcode detection.
module mc_control #(
    parameter int STATEBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 sign,
    input  logic                 overflow,
    input  logic                 memready,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 iord,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 irwrite,
    output logic                 pcen,
    output logic [1:0]           pcsource,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [4:0]           alucont,
    output logic                 ovf_trap,
    output logic                 illegal,
    output logic [STATEBITS-1:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, REX = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        JR = 4'd10, IEX = 4'd11, IWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;

    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010;
    localparam logic [5:0] F_JR = 6'b001000;

    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR = 5'b00011, ALU_XOR = 5'b00100, ALU_NOR = 5'b00101;
    localparam logic [4:0] ALU_SLT = 5'b00110;

    state_t state_q, state_d, out_state;
    logic   ovf_q, ovf_d;
    logic   op_legal;
    logic   unused_sign;

    // sign is reserved for blez/bgtz and has no effect yet
    assign unused_sign = sign;

    function automatic logic [4:0] rtype_alu(input logic [5:0] f);
        case (f)
            F_ADD, F_ADDU: return ALU_ADD;
            F_SUB, F_SUBU: return ALU_SUB;
            F_AND:         return ALU_AND;
            F_OR:          return ALU_OR;
            F_XOR:         return ALU_XOR;
            F_NOR:         return ALU_NOR;
            F_SLT:         return ALU_SLT;
            default:       return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        case (op)
            OP_R:    op_legal = funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND,
                                              F_OR, F_XOR, F_NOR, F_SLT, F_JR};
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ADDIU, OP_SLTI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        ovf_d   = ovf_q;
        case (state_q)
            FETCH: begin
                state_d = DECODE;
                ovf_d   = 1'b0;
            end
            DECODE: begin
                if (!op_legal) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        OP_R:          state_d = (funct == F_JR) ? JR : REX;
                        OP_LW, OP_SW:  state_d = MEMADR;
                        OP_BEQ, OP_BNE: state_d = BRANCH;
                        OP_J:          state_d = JUMP;
                        default:       state_d = IEX;
                    endcase
                end
            end
            MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = memready ? MEMWB : MEMRD;
            MEMWR:  state_d = memready ? FETCH : MEMWR;
            REX: begin
                state_d = RWB;
                ovf_d   = overflow & ((funct == F_ADD) | (funct == F_SUB));
            end
            IEX: begin
                state_d = IWB;
                ovf_d   = overflow & (op == OP_ADDI);
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // During reset the outputs show FETCH with every strobe held low
    assign out_state = reset ? FETCH : state_q;
    assign state     = STATEBITS'(out_state);

    always_comb begin
        memwrite = 1'b0;
        memtoreg = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        pcsource = 2'b00;
        alusrca  = 2'b00;
        alusrcb  = 2'b00;
        alucont  = ALU_ADD;
        ovf_trap = 1'b0;
        illegal  = 1'b0;
        case (out_state)
            FETCH: begin
                alusrcb = 2'b01;
                pcen    = ~reset;
                irwrite = ~reset;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_legal;
            end
            MEMADR: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            REX: begin
                alusrca = 2'b01;
                alucont = rtype_alu(funct);
            end
            RWB: begin
                regdst   = 1'b1;
                regwrite = ~ovf_q;
                ovf_trap = ovf_q;
            end
            IEX: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                alucont = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            IWB: begin
                regwrite = ~ovf_q;
                ovf_trap = ovf_q;
            end
            BRANCH: begin
                alusrca  = 2'b01;
                alucont  = ALU_SUB;
                pcsource = 2'b01;
                pcen     = (op == OP_BEQ) ? zero : ~zero;
            end
            JUMP: begin
                pcsource = 2'b10;
                pcen     = 1'b1;
            end
            JR: begin
                pcsource = 2'b11;
                pcen     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control: one vector per clock cycle, all outputs compared.
module tb_mc_control;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic       zero = 1'b0, sign = 1'b0, overflow = 1'b0, memready = 1'b1;
    logic       memwrite, memtoreg, iord, regwrite, regdst, irwrite, pcen, ovf_trap, illegal;
    logic [1:0] pcsource, alusrca, alusrcb;
    logic [4:0] alucont;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_control #(.STATEBITS(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .overflow(overflow), .memready(memready), .memwrite(memwrite), .memtoreg(memtoreg),
        .iord(iord), .regwrite(regwrite), .regdst(regdst), .irwrite(irwrite), .pcen(pcen),
        .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
        .ovf_trap(ovf_trap), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        z;
        logic        ov;
        logic        mr;
        logic [23:0] exp;
    } vec_t;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] J = 6'h02, ADDI = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A;

    // Expected vector: {state, pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
    // pcsource, alusrca, alusrcb, alucont, ovf_trap, illegal}
    function automatic logic [23:0] ex(int st, int pc, int irw, int rw, int mw, int io, int rd,
                                       int m2r, int pcs, int sa, int sb, int alu, int tr, int il);
        return {st[3:0], pc[0], irw[0], rw[0], mw[0], io[0], rd[0], m2r[0],
                pcs[1:0], sa[1:0], sb[1:0], alu[4:0], tr[0], il[0]};
    endfunction

    function automatic vec_t mk(string n, logic r, logic [5:0] o, logic [5:0] f,
                                logic z, logic ov, logic mr, logic [23:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.funct = f; v.z = z; v.ov = ov; v.mr = mr; v.exp = e;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic [23:0] act;
        @(negedge clk);
        reset = v.rst; op = v.op; funct = v.funct; zero = v.z; sign = ~v.z;
        overflow = v.ov; memready = v.mr;
        #1;
        act = {state, pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
               pcsource, alusrca, alusrcb, alucont, ovf_trap, illegal};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", v.name, act, v.exp);
        end
    endtask

    vec_t tbl[$];
    logic [23:0] EF, ED, ERST, EMA, EMRD, EMWB, EMWR;

    initial begin
        int rt_f[10]  = '{6'h20, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        int rt_ov[10] = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 1};
        int rt_al[10] = '{0, 0, 0, 1, 1, 2, 3, 4, 5, 6};
        int rt_tr[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        int it_op[4]  = '{ADDI, ADDI, ADDIU, SLTI};
        int it_ov[4]  = '{0, 1, 1, 1};
        int it_al[4]  = '{0, 0, 0, 6};
        int it_tr[4]  = '{0, 1, 0, 0};
        int br_op[4]  = '{BEQ, BEQ, BNE, BNE};
        int br_z[4]   = '{1, 0, 0, 1};
        int br_pc[4]  = '{1, 0, 1, 0};
        logic [5:0] o6, f6;

        EF   = ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        ED   = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        ERST = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        EMA  = ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        EMRD = ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        EMWB = ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        EMWR = ex(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk("rst_a", 1, R, 0, 0, 0, 1, ERST));
        tbl.push_back(mk("rst_b", 1, R, 0, 0, 0, 1, ERST));
        for (int i = 0; i < 10; i++) begin
            f6 = rt_f[i][5:0];
            tbl.push_back(mk($sformatf("rt%0d_fetch", i), 0, R, f6, 0, 0, 1, EF));
            tbl.push_back(mk($sformatf("rt%0d_decode", i), 0, R, f6, 0, 0, 1, ED));
            tbl.push_back(mk($sformatf("rt%0d_rex", i), 0, R, f6, 0, rt_ov[i][0], 1,
                             ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rt_al[i], 0, 0)));
            tbl.push_back(mk($sformatf("rt%0d_rwb", i), 0, R, f6, 0, 0, 1,
                             ex(7, 0, 0, 1 - rt_tr[i], 0, 0, 1, 0, 0, 0, 0, 0, rt_tr[i], 0)));
        end
        for (int i = 0; i < 4; i++) begin
            o6 = it_op[i][5:0];
            tbl.push_back(mk($sformatf("it%0d_fetch", i), 0, o6, 0, 0, 0, 1, EF));
            tbl.push_back(mk($sformatf("it%0d_decode", i), 0, o6, 0, 0, 0, 1, ED));
            tbl.push_back(mk($sformatf("it%0d_iex", i), 0, o6, 0, 0, it_ov[i][0], 1,
                             ex(11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, it_al[i], 0, 0)));
            tbl.push_back(mk($sformatf("it%0d_iwb", i), 0, o6, 0, 0, 0, 1,
                             ex(12, 0, 0, 1 - it_tr[i], 0, 0, 0, 0, 0, 0, 0, 0, it_tr[i], 0)));
        end
        for (int i = 0; i < 4; i++) begin
            o6 = br_op[i][5:0];
            tbl.push_back(mk($sformatf("br%0d_fetch", i), 0, o6, 0, br_z[i][0], 0, 1, EF));
            tbl.push_back(mk($sformatf("br%0d_decode", i), 0, o6, 0, br_z[i][0], 0, 1, ED));
            tbl.push_back(mk($sformatf("br%0d_branch", i), 0, o6, 0, br_z[i][0], 0, 1,
                             ex(8, br_pc[i], 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0)));
        end
        tbl.push_back(mk("sw_fetch", 0, SW, 0, 0, 0, 1, EF));
        tbl.push_back(mk("sw_decode", 0, SW, 0, 0, 0, 1, ED));
        tbl.push_back(mk("sw_memadr", 0, SW, 0, 0, 0, 1, EMA));
        tbl.push_back(mk("sw_memwr", 0, SW, 0, 0, 0, 1, EMWR));
        tbl.push_back(mk("j_fetch", 0, J, 0, 0, 0, 1, EF));
        tbl.push_back(mk("j_decode", 0, J, 0, 0, 0, 1, ED));
        tbl.push_back(mk("j_jump", 0, J, 0, 0, 0, 1, ex(9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0)));
        tbl.push_back(mk("jr_fetch", 0, R, 6'h08, 0, 0, 1, EF));
        tbl.push_back(mk("jr_decode", 0, R, 6'h08, 0, 0, 1, ED));
        tbl.push_back(mk("jr_jr", 0, R, 6'h08, 0, 0, 1, ex(10, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0)));
        tbl.push_back(mk("ill_fetch", 0, 6'h3F, 0, 0, 1, 0, EF));
        tbl.push_back(mk("ill_decode", 0, 6'h3F, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1)));
        tbl.push_back(mk("ill_refetch", 0, 6'h3F, 0, 0, 1, 0, EF));
        tbl.push_back(mk("ill_decode2", 0, 6'h3F, 0, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1)));

        foreach (tbl[i]) apply(tbl[i]);

        // lw with memready low for two cycles: 7 cycles total
        apply(mk("lw_fetch", 0, LW, 0, 0, 0, 0, EF));
        apply(mk("lw_decode", 0, LW, 0, 0, 0, 0, ED));
        apply(mk("lw_memadr", 0, LW, 0, 0, 0, 0, EMA));
        apply(mk("lw_memrd_w1", 0, LW, 0, 0, 0, 0, EMRD));
        apply(mk("lw_memrd_w2", 0, LW, 0, 0, 0, 0, EMRD));
        apply(mk("lw_memrd_go", 0, LW, 0, 0, 0, 1, EMRD));
        apply(mk("lw_memwb", 0, LW, 0, 0, 0, 0, EMWB));

        // sw with one wait cycle keeps memwrite high throughout MEMWR
        apply(mk("sww_fetch", 0, SW, 0, 0, 0, 1, EF));
        apply(mk("sww_decode", 0, SW, 0, 0, 0, 1, ED));
        apply(mk("sww_memadr", 0, SW, 0, 0, 0, 1, EMA));
        apply(mk("sww_memwr_w", 0, SW, 0, 0, 0, 0, EMWR));
        apply(mk("sww_memwr_go", 0, SW, 0, 0, 0, 1, EMWR));

        // reset held three cycles in the middle of a MEMRD wait
        apply(mk("rlw_fetch", 0, LW, 0, 0, 0, 0, EF));
        apply(mk("rlw_decode", 0, LW, 0, 0, 0, 0, ED));
        apply(mk("rlw_memadr", 0, LW, 0, 0, 0, 0, EMA));
        apply(mk("rlw_memrd", 0, LW, 0, 0, 0, 0, EMRD));
        apply(mk("rlw_rst1", 1, LW, 0, 0, 0, 0, ERST));
        apply(mk("rlw_rst2", 1, LW, 0, 0, 0, 0, ERST));
        apply(mk("rlw_rst3", 1, LW, 0, 0, 0, 0, ERST));
        apply(mk("rlw_post_fetch", 0, J, 0, 0, 0, 0, EF));
        apply(mk("rlw_post_decode", 0, J, 0, 0, 0, 0, ED));
        apply(mk("rlw_post_jump", 0, J, 0, 0, 0, 0, ex(9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0)));

        // reset landing on RWB with a pending overflow must not trap or write
        apply(mk("rovf_fetch", 0, R, 6'h20, 0, 0, 1, EF));
        apply(mk("rovf_decode", 0, R, 6'h20, 0, 0, 1, ED));
        apply(mk("rovf_rex", 0, R, 6'h20, 0, 1, 1, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
        apply(mk("rovf_rst", 1, R, 6'h20, 0, 0, 1, ERST));
        apply(mk("rovf_post_fetch", 0, R, 6'h20, 0, 0, 1, EF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end
endmodule
